// File: rtl/astro_vtg_pkg.sv
// Shared definitions for the Astrocade-style raster timing generator:
// counter width, default timing constants, the sync output bundle and
// the modular window-hit helper used by both axis decoders.
package astro_vtg_pkg;

    localparam int CNT_W = 9;

    localparam int VTG_CE_DIV      = 16;
    localparam int VTG_H_TOTAL     = 455;
    localparam int VTG_H_ACT_START = 34;
    localparam int VTG_H_ACT_END   = 214;
    localparam int VTG_HS_START    = 0;
    localparam int VTG_HS_WIDTH    = 32;
    localparam int VTG_V_TOTAL     = 262;
    localparam int VTG_V_ACT_START = 25;
    localparam int VTG_V_ACT_END   = 255;
    localparam int VTG_VS_START    = 0;
    localparam int VTG_VS_WIDTH    = 3;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
        logic de;
        logic line_start;
        logic frame_start;
    } vtg_out_t;

    localparam vtg_out_t VTG_OUT_RESET = '{hsync: 1'b0, vsync: 1'b0, hblank: 1'b1, vblank: 1'b1,
                                           de: 1'b0, line_start: 1'b0, frame_start: 1'b0};

    // True when n lies in [start, start+width) taken modulo total; the
    // window may straddle the wrap point of the counter.
    function automatic logic in_window(input logic [CNT_W:0] n, input logic [CNT_W:0] start,
                                       input logic [CNT_W:0] width, input logic [CNT_W:0] total);
        logic [CNT_W+1:0] stop_s;
        logic             hit_s;
        stop_s = {1'b0, start} + {1'b0, width};
        if (stop_s <= {1'b0, total}) begin
            hit_s = (n >= start) && ({1'b0, n} < stop_s);
        end else begin
            hit_s = (n >= start) || ({1'b0, n} < (stop_s - {1'b0, total}));
        end
        return hit_s;
    endfunction

endpackage

// File: rtl/astro_vtg_axis.sv
// One raster axis: a modulo-TOTAL counter that advances on step, plus the
// blank and sync window decode of the value it is about to take. The
// decode is of the next count so the caller can register it alongside the
// counter and keep every output coherent with the new position.
module astro_vtg_axis
    import astro_vtg_pkg::*;
#(
    parameter int TOTAL      = 455,
    parameter int ACT_START  = 34,
    parameter int ACT_END    = 214,
    parameter int SYNC_START = 0,
    parameter int SYNC_WIDTH = 32
) (
    input  logic             CLK_VIDEO,
    input  logic             reset,
    input  logic             step,
    output logic [CNT_W-1:0] count_next,
    output logic             wrap,
    output logic             blank_next,
    output logic             sync_next
);

    localparam int CW1 = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W:0]   TOT_C   = CW1'(TOTAL);
    localparam logic [CNT_W:0]   ACT_S_C = CW1'(ACT_START);
    localparam logic [CNT_W:0]   ACT_E_C = CW1'(ACT_END);
    localparam logic [CNT_W:0]   SYN_S_C = CW1'(SYNC_START);
    localparam logic [CNT_W:0]   SYN_W_C = CW1'(SYNC_WIDTH);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W:0]   next_ext_s;

    // Next-count computation and window decode of that next count
    always_comb begin
        wrap = step & (count_r == LAST);
        if (wrap) begin
            count_next = '0;
        end else if (step) begin
            count_next = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_next = count_r;
        end
        next_ext_s = {1'b0, count_next};
        blank_next = (next_ext_s < ACT_S_C) || (next_ext_s >= ACT_E_C);
        sync_next  = in_window(next_ext_s, SYN_S_C, SYN_W_C, TOT_C);
    end

    // Position register; parks on the last index so the first step lands on 0
    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            count_r <= LAST;
        end else begin
            count_r <= count_next;
        end
    end

endmodule

// File: rtl/astro_video_timing_gen.sv
// Raster timing transmitter: 1/CE_DIV pixel enable, h/v counters, sync,
// blanking, data-enable and line/frame markers, all registered on the
// pixel-enable edge so they are coherent while ce_pix is high.
// Optional colour-bar test pattern: define ASTRO_VTG_PATTERN_EN.
module astro_video_timing_gen
    import astro_vtg_pkg::*;
#(
    parameter int CE_DIV      = VTG_CE_DIV,
    parameter int H_TOTAL     = VTG_H_TOTAL,
    parameter int H_ACT_START = VTG_H_ACT_START,
    parameter int H_ACT_END   = VTG_H_ACT_END,
    parameter int HS_START    = VTG_HS_START,
    parameter int HS_WIDTH    = VTG_HS_WIDTH,
    parameter int V_TOTAL     = VTG_V_TOTAL,
    parameter int V_ACT_START = VTG_V_ACT_START,
    parameter int V_ACT_END   = VTG_V_ACT_END,
    parameter int VS_START    = VTG_VS_START,
    parameter int VS_WIDTH    = VTG_VS_WIDTH
) (
    input  logic             CLK_VIDEO,
    input  logic             reset,
    input  logic             enable,
    output logic             ce_pix,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic [3:0]       pat_r,
    output logic [3:0]       pat_g,
    output logic [3:0]       pat_b
);

    if ((H_ACT_END > H_TOTAL) || (V_ACT_END > V_TOTAL) || (HS_WIDTH == 0) || (HS_WIDTH >= H_TOTAL) ||
        (VS_WIDTH == 0) || (VS_WIDTH >= V_TOTAL) || (CE_DIV < 2) || (CE_DIV > 16)) begin : g_bad_params
        $error("astro_video_timing_gen: illegal timing parameters");
    end

    localparam logic [3:0]       DIV_LAST = 4'(CE_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [3:0]       div_r;
    logic             ce_pix_r;
    logic             tick_s;
    vtg_out_t         out_r;
    vtg_out_t         out_next_s;
    logic [CNT_W-1:0] hcount_r;
    logic [CNT_W-1:0] vcount_r;
    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             h_blank_s;
    logic             v_blank_s;
    logic             h_sync_s;
    logic             v_sync_s;

    assign tick_s = enable & (div_r == DIV_LAST);

    astro_vtg_axis #(
        .TOTAL(H_TOTAL), .ACT_START(H_ACT_START), .ACT_END(H_ACT_END),
        .SYNC_START(HS_START), .SYNC_WIDTH(HS_WIDTH)
    ) u_h_axis (
        .CLK_VIDEO(CLK_VIDEO), .reset(reset), .step(tick_s),
        .count_next(h_next_s), .wrap(h_wrap_s), .blank_next(h_blank_s), .sync_next(h_sync_s)
    );

    astro_vtg_axis #(
        .TOTAL(V_TOTAL), .ACT_START(V_ACT_START), .ACT_END(V_ACT_END),
        .SYNC_START(VS_START), .SYNC_WIDTH(VS_WIDTH)
    ) u_v_axis (
        .CLK_VIDEO(CLK_VIDEO), .reset(reset), .step(h_wrap_s),
        .count_next(v_next_s), .wrap(v_wrap_s), .blank_next(v_blank_s), .sync_next(v_sync_s)
    );

    // Pixel divider: free-runs 0..CE_DIV-1 while enabled, frozen otherwise
    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            div_r <= 4'h0;
        end else if (tick_s) begin
            div_r <= 4'h0;
        end else if (enable) begin
            div_r <= div_r + 4'h1;
        end else begin
            div_r <= div_r;
        end
    end

    // Registered pixel enable, high for the cycle after the divider's last count
    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            ce_pix_r <= 1'b0;
        end else begin
            ce_pix_r <= tick_s;
        end
    end

    // Assemble the sync bundle for the position the counters are moving to
    always_comb begin
        out_next_s             = VTG_OUT_RESET;
        out_next_s.hsync       = h_sync_s;
        out_next_s.vsync       = v_sync_s;
        out_next_s.hblank      = h_blank_s;
        out_next_s.vblank      = v_blank_s;
        out_next_s.de          = ~(h_blank_s | v_blank_s);
        out_next_s.line_start  = h_wrap_s;
        out_next_s.frame_start = v_wrap_s;
    end

    // Output bank: loads on the pixel-enable edge, holds between pulses
    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            out_r    <= VTG_OUT_RESET;
            hcount_r <= H_LAST;
            vcount_r <= V_LAST;
        end else if (tick_s) begin
            out_r    <= out_next_s;
            hcount_r <= h_next_s;
            vcount_r <= v_next_s;
        end else begin
            out_r    <= out_r;
            hcount_r <= hcount_r;
            vcount_r <= vcount_r;
        end
    end

`ifdef ASTRO_VTG_PATTERN_EN
    localparam int ACT_W = H_ACT_END - H_ACT_START;
    localparam logic [CNT_W-1:0] H_ACT_S = CNT_W'(H_ACT_START);

    logic [12:0] x8_s;
    logic [2:0]  bar_s;
    logic [3:0]  pat_r_r;
    logic [3:0]  pat_g_r;
    logic [3:0]  pat_b_r;

    // Bar index = largest k with 8*x >= k*ACT_W, i.e. floor(8*x/ACT_W) without a divider
    always_comb begin
        x8_s  = {1'b0, h_next_s - H_ACT_S, 3'b000};
        bar_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x8_s >= 13'(k * ACT_W)) begin
                bar_s = 3'(k);
            end else begin
                bar_s = bar_s;
            end
        end
    end

    // Colour-bar registers, black outside the active area
    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            pat_r_r <= 4'h0;
            pat_g_r <= 4'h0;
            pat_b_r <= 4'h0;
        end else if (tick_s) begin
            if (out_next_s.de) begin
                pat_r_r <= {4{bar_s[2]}};
                pat_g_r <= {4{bar_s[1]}};
                pat_b_r <= {4{bar_s[0]}};
            end else begin
                pat_r_r <= 4'h0;
                pat_g_r <= 4'h0;
                pat_b_r <= 4'h0;
            end
        end else begin
            pat_r_r <= pat_r_r;
            pat_g_r <= pat_g_r;
            pat_b_r <= pat_b_r;
        end
    end

    assign pat_r = pat_r_r;
    assign pat_g = pat_g_r;
    assign pat_b = pat_b_r;
`else
    assign pat_r = 4'h0;
    assign pat_g = 4'h0;
    assign pat_b = 4'h0;
`endif

    assign ce_pix      = ce_pix_r;
    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign hsync       = out_r.hsync;
    assign vsync       = out_r.vsync;
    assign hblank      = out_r.hblank;
    assign vblank      = out_r.vblank;
    assign de          = out_r.de;
    assign line_start  = out_r.line_start;
    assign frame_start = out_r.frame_start;

endmodule

// File: tb/tb_astro_video_timing_gen.sv
// Scoreboard bench for astro_video_timing_gen with a shrunken raster
// (40x16 pixels, CE_DIV kept at 16) so whole frames fit in a short run.
// Stimulus pushes expected pixels into a queue; the monitor pops one per
// ce_pix and also checks hold behaviour, reset values, line/frame periods
// and an hs/vs edge-counting receiver.
module tb_astro_video_timing_gen;

    localparam int CE_DIV = 16;
    localparam int H_TOTAL = 40, HAS = 6, HAE = 30, HS_START = 36, HS_WIDTH = 8;
    localparam int V_TOTAL = 16, VAS = 3, VAE = 13, VS_START = 0, VS_WIDTH = 3;

    logic       CLK_VIDEO = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       ce_pix, hsync, vsync, hblank, vblank, de, line_start, frame_start;
    logic [8:0] hcount, vcount;
    logic [3:0] pat_r, pat_g, pat_b;

    astro_video_timing_gen #(
        .CE_DIV(CE_DIV), .H_TOTAL(H_TOTAL), .H_ACT_START(HAS), .H_ACT_END(HAE),
        .HS_START(HS_START), .HS_WIDTH(HS_WIDTH), .V_TOTAL(V_TOTAL), .V_ACT_START(VAS),
        .V_ACT_END(VAE), .VS_START(VS_START), .VS_WIDTH(VS_WIDTH)
    ) dut (
        .CLK_VIDEO(CLK_VIDEO), .reset(reset), .enable(enable), .ce_pix(ce_pix),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .de(de), .line_start(line_start),
        .frame_start(frame_start), .pat_r(pat_r), .pat_g(pat_g), .pat_b(pat_b)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic hs, vs, hb, vb, de, ls, fs;
        logic [3:0] r, g, b;
    } px_t;

    px_t exp_q[$];
    px_t last_exp;
    int  n_vec = 0;
    int  n_err = 0;
    int  mh, mv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic px_t model_px(input int h, input int v);
        px_t p;
        int  bar;
        p.h  = 9'(h);
        p.v  = 9'(v);
        p.hs = ((h + H_TOTAL - HS_START) % H_TOTAL) < HS_WIDTH;
        p.vs = ((v + V_TOTAL - VS_START) % V_TOTAL) < VS_WIDTH;
        p.hb = (h < HAS) || (h >= HAE);
        p.vb = (v < VAS) || (v >= VAE);
        p.de = !(p.hb || p.vb);
        p.ls = (h == 0);
        p.fs = (h == 0) && (v == 0);
        p.r = 4'h0; p.g = 4'h0; p.b = 4'h0;
        bar = 0;
`ifdef ASTRO_VTG_PATTERN_EN
        if (p.de) begin
            bar = ((h - HAS) * 8) / (HAE - HAS);
            p.r = bar[2] ? 4'hF : 4'h0;
            p.g = bar[1] ? 4'hF : 4'h0;
            p.b = bar[0] ? 4'hF : 4'h0;
        end
`endif
        return p;
    endfunction

    function automatic px_t rst_px();
        px_t p;
        p = '0;
        p.h = 9'(H_TOTAL - 1);
        p.v = 9'(V_TOTAL - 1);
        p.hb = 1'b1;
        p.vb = 1'b1;
        return p;
    endfunction

    function automatic px_t dut_px();
        px_t p;
        p.h = hcount; p.v = vcount;
        p.hs = hsync; p.vs = vsync; p.hb = hblank; p.vb = vblank; p.de = de;
        p.ls = line_start; p.fs = frame_start;
        p.r = pat_r; p.g = pat_g; p.b = pat_b;
        return p;
    endfunction

    task automatic model_reset();
        mh = H_TOTAL - 1;
        mv = V_TOTAL - 1;
    endtask

    task automatic push_px(input int n);
        for (int i = 0; i < n; i++) begin
            if (mh == H_TOTAL - 1) begin
                mh = 0;
                mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            exp_q.push_back(model_px(mh, mv));
        end
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge CLK_VIDEO);
            c++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Counts clocks from now to the first ce_pix and checks the first pixel by hand
    task automatic first_ce_check();
        int cyc = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 64) begin
            @(posedge CLK_VIDEO);
            #1;
            cyc++;
            if (ce_pix) seen = 1'b1;
        end
        check("first_ce_cycle", cyc, CE_DIV);
        check("first_hcount", hcount, 0);
        check("first_vcount", vcount, 0);
        check("first_frame_start", frame_start, 1);
        check("first_line_start", line_start, 1);
        check("first_hsync", hsync, 1);
        check("first_hblank", hblank, 1);
        check("first_vblank", vblank, 1);
    endtask

    // Monitor state
    int ls_cnt, fs_cnt, hs_run, rx_h, rx_v, rx_h_n, rx_v_n;
    bit ls_seen, fs_seen, hs_run_ok, hs_prev, vs_prev, hs_low_seen, vs_low_seen, rx_hlock, rx_vlock;
    bit hs_rise, vs_rise;

    always @(posedge CLK_VIDEO) begin
        #1;
        if (reset) begin
            check("reset_state", {ce_pix, dut_px()}, {1'b0, rst_px()});
            last_exp = rst_px();
            ls_cnt = 0; fs_cnt = 0; hs_run = 0; rx_h = 0; rx_v = 0;
            ls_seen = 0; fs_seen = 0; hs_run_ok = 0; hs_prev = 0; vs_prev = 0;
            hs_low_seen = 0; vs_low_seen = 0; rx_hlock = 0; rx_vlock = 0;
        end else if (ce_pix) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ce_pix", 1, 0);
            end else begin
                last_exp = exp_q.pop_front();
                check("pixel", dut_px(), last_exp);
            end
            ls_cnt++;
            fs_cnt++;
            if (line_start) begin
                if (ls_seen) check("ce_per_line", ls_cnt, H_TOTAL);
                ls_seen = 1; ls_cnt = 0;
            end
            if (frame_start) begin
                if (fs_seen) check("ce_per_frame", fs_cnt, H_TOTAL * V_TOTAL);
                fs_seen = 1; fs_cnt = 0;
            end
            hs_rise = hsync && !hs_prev && hs_low_seen;
            vs_rise = vsync && !vs_prev && vs_low_seen;
            if (hs_rise) begin hs_run_ok = 1; hs_run = 0; end
            if (hsync) hs_run++;
            else begin
                if (hs_run_ok) check("hsync_width", hs_run, HS_WIDTH);
                hs_run_ok = 0;
            end
            if (vsync != vs_prev) check("vsync_edge_at_h0", hcount, 0);
            // emu-style receiver: position recovered from hs/vs rising edges
            rx_h_n = (rx_h == H_TOTAL - 1) ? 0 : rx_h + 1;
            if (hs_rise) begin rx_h_n = HS_START; rx_hlock = 1; end
            rx_v_n = rx_v;
            if (rx_h_n == 0) rx_v_n = (rx_v == V_TOTAL - 1) ? 0 : rx_v + 1;
            if (vs_rise) begin rx_v_n = VS_START; rx_vlock = 1; end
            rx_h = rx_h_n;
            rx_v = rx_v_n;
            if (rx_hlock) check("rx_hblank", hblank, (rx_h < HAS) || (rx_h >= HAE));
            if (rx_vlock) check("rx_vblank", vblank, (rx_v < VAS) || (rx_v >= VAE));
`ifdef ASTRO_VTG_PATTERN_EN
            if (de && hcount == HAS) check("pat_first_black", {pat_r, pat_g, pat_b}, 12'h000);
            if (de && hcount == HAE - 1) check("pat_last_white", {pat_r, pat_g, pat_b}, 12'hFFF);
`endif
            if (!hsync) hs_low_seen = 1;
            if (!vsync) vs_low_seen = 1;
            hs_prev = hsync;
            vs_prev = vsync;
        end else begin
            check("hold_between_ce", dut_px(), last_exp);
        end
    end

    initial begin
        model_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge CLK_VIDEO);
        reset = 1'b0;
        repeat (2) @(negedge CLK_VIDEO);
        // first pixel after reset, then three full frames ending at (10,0)
        push_px(1);
        enable = 1'b1;
        first_ce_check();
        push_px(1930);
        drain(1930 * CE_DIV + 64);
        // pause mid-line right after pixel (10,0); resume must give (11,0)
        enable = 1'b0;
        repeat (40) @(negedge CLK_VIDEO);
        push_px(420);
        enable = 1'b1;
        drain(420 * CE_DIV + 64);
        // asynchronous reset mid-frame at (30,10)
        repeat (5) @(negedge CLK_VIDEO);
        check("pre_reset_hcount", hcount, 30);
        check("pre_reset_vcount", vcount, 10);
        reset = 1'b1;
        #1;
        check("async_reset_hcount", hcount, H_TOTAL - 1);
        check("async_reset_vcount", vcount, V_TOTAL - 1);
        check("async_reset_hblank", hblank, 1);
        check("async_reset_de", de, 0);
        check("async_reset_ce_pix", ce_pix, 0);
        repeat (3) @(negedge CLK_VIDEO);
        model_reset();
        push_px(1);
        reset = 1'b0;
        first_ce_check();
        push_px(44);
        drain(44 * CE_DIV + 64);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
